// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU/multiplier block.
// Optional feature macro: ALU_MUL_EARLY_EXIT_EN (early exit of the shift-add loop).
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic       OP_PASS      = 1'b0;
    localparam logic       OP_MUL       = 1'b1;
    localparam logic [5:0] ALU_CTRL_ADD = 6'b000010;
    localparam int         MUL_ITERS    = 16;
    localparam int         CNT_W        = $clog2(MUL_ITERS);

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Combinational 16-bit ALU with control {zx,nx,zy,ny,f,no}; the block's only adder.
module alu_mul_seq_alu (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [5:0]  ctrl_i,
    output logic [15:0] out_o
);

    logic [15:0] xz, xn, yz, yn, fo;

    assign xz    = ctrl_i[5] ? 16'h0000 : x_i;
    assign xn    = ctrl_i[4] ? ~xz : xz;
    assign yz    = ctrl_i[3] ? 16'h0000 : y_i;
    assign yn    = ctrl_i[2] ? ~yz : yz;
    assign fo    = ctrl_i[1] ? (xn + yn) : (xn & yn);
    assign out_o = ctrl_i[0] ? ~fo : fo;

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential ALU: single-pass ALU operation or 16x16 shift-add multiply (low 16 bits).
// Optional feature macro: ALU_MUL_EARLY_EXIT_EN (leave MUL once the multiplier is exhausted).
module alu_mul_seq
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic        op,
    input  logic [5:0]  ctrl,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] res,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        zr,
    output logic        ng,
    output logic        busy
);

    state_e             state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        mcand_q, mcand_d;
    logic [15:0]        mplier_q, mplier_d;
    logic [5:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        res_q, res_d;

    logic [15:0]        aluX, aluY, aluOut;
    logic [5:0]         aluCtrl;
    logic [15:0]        accNext, mplierNext;
    logic               mulLast;

    // mcand/mplier double as the captured x/y operands for PASS
    always_comb begin
        aluX    = mcand_q;
        aluY    = mplier_q;
        aluCtrl = ctrl_q;
        if (state_q == ST_MUL) begin
            aluX    = acc_q;
            aluY    = mcand_q;
            aluCtrl = ALU_CTRL_ADD;
        end
    end

    alu_mul_seq_alu u_alu (
        .x_i    (aluX),
        .y_i    (aluY),
        .ctrl_i (aluCtrl),
        .out_o  (aluOut)
    );

    assign accNext    = mplier_q[0] ? aluOut : acc_q;
    assign mplierNext = {1'b0, mplier_q[15:1]};

`ifdef ALU_MUL_EARLY_EXIT_EN
    assign mulLast = (mplierNext == 16'h0000) || (cnt_q == CNT_W'(MUL_ITERS - 1));
`else
    assign mulLast = (cnt_q == CNT_W'(MUL_ITERS - 1));
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    acc_d    = 16'h0000;
                    mcand_d  = a;
                    mplier_d = b;
                    ctrl_d   = ctrl;
                    cnt_d    = '0;
                    state_d  = (op == OP_MUL) ? ST_MUL : ST_PASS;
                end
            end
            ST_PASS: begin
                res_d   = aluOut;
                state_d = ST_DONE;
            end
            ST_MUL: begin
                acc_d    = accNext;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = mplierNext;
                cnt_d    = cnt_q + 1'b1;
                if (mulLast) begin
                    res_d   = accNext;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            ctrl_q   <= 6'h00;
            cnt_q    <= '0;
            res_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign res         = res_q;
    assign zr          = (res_q == 16'h0000);
    assign ng          = res_q[15];

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed cases plus randomized PASS/MUL traffic.
// Latency expectations follow ALU_MUL_EARLY_EXIT_EN when it is defined for the build.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic        op;
    logic [5:0]  ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        res_valid;
    logic        res_ready;
    logic        zr;
    logic        ng;
    logic        busy;

    int compareCount  = 0;
    int mismatchCount = 0;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .ctrl        (ctrl),
        .a           (a),
        .b           (b),
        .res         (res),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .zr          (zr),
        .ng          (ng),
        .busy        (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU written from the control-bit definitions
    function automatic logic [15:0] aluRef(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] xv, yv, fv;
        xv = c[5] ? 16'h0000 : x;
        if (c[4]) xv = 16'hFFFF - xv;
        yv = c[3] ? 16'h0000 : y;
        if (c[2]) yv = 16'hFFFF - yv;
        fv = c[1] ? 16'((32'(xv) + 32'(yv)) % 65536) : (xv & yv);
        if (c[0]) fv = 16'hFFFF - fv;
        return fv;
    endfunction

    function automatic logic [15:0] mulRef(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = 32'(x) * 32'(y);
        return p[15:0];
    endfunction

    // Edges from acceptance (counted as edge 1) until res_valid is seen
    function automatic int latencyRef(input logic opv, input logic [15:0] y);
        int iters;
        if (opv == 1'b0) return 2;
        iters = 16;
`ifdef ALU_MUL_EARLY_EXIT_EN
        iters = 1;
        for (int i = 15; i >= 0; i--) begin
            if (y[i]) begin
                iters = i + 1;
                break;
            end
        end
`endif
        return iters + 1;
    endfunction

    task automatic applyStimulus(input logic opv, input logic [5:0] c, input logic [15:0] av,
                                 input logic [15:0] bv, input int readyDelay, input bit holdStart);
        logic [15:0] expRes;
        logic [15:0] held;
        int          edges;
        expRes = opv ? mulRef(av, bv) : aluRef(c, av, bv);
        @(negedge clk);
        checkOutput("start_ready idle", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        op   = opv;
        ctrl = c;
        a    = av;
        b    = bv;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start_valid = holdStart;
        op   = 1'($urandom);
        ctrl = 6'($urandom);
        a    = 16'($urandom);
        b    = 16'($urandom);
        checkOutput("busy after accept", 32'(busy), 32'd1);
        while (!res_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("latency", 32'(edges), 32'(latencyRef(opv, bv)));
        checkOutput("res", 32'(res), 32'(expRes));
        checkOutput("zr", 32'(zr), 32'(expRes == 16'h0000));
        checkOutput("ng", 32'(ng), 32'(expRes[15]));
        checkOutput("start_ready in done", 32'(start_ready), 32'd0);
        held = res;
        repeat (readyDelay) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("res stable", 32'(res), 32'(held));
            checkOutput("res_valid held", 32'(res_valid), 32'd1);
            checkOutput("start_ready held low", 32'(start_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready   = 1'b0;
        start_valid = 1'b0;
        checkOutput("start_ready after release", 32'(start_ready), 32'd1);
        checkOutput("res_valid after release", 32'(res_valid), 32'd0);
        checkOutput("busy after release", 32'(busy), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " start_ready"}, 32'(start_ready), 32'd1);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " res_valid"}, 32'(res_valid), 32'd0);
        checkOutput({tag, " res"}, 32'(res), 32'd0);
        checkOutput({tag, " zr"}, 32'(zr), 32'd1);
        checkOutput({tag, " ng"}, 32'(ng), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        op          = 1'b0;
        ctrl        = 6'h00;
        a           = 16'h0000;
        b           = 16'h0000;
        res_ready   = 1'b0;
        #1;
        checkResetState("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 6'b000010, 16'd3, 16'd5, 0, 1'b0);
        applyStimulus(1'b1, 6'b000000, 16'd7, 16'd6, 1, 1'b0);
        applyStimulus(1'b1, 6'b111111, 16'hFFFD, 16'd5, 0, 1'b0);
        applyStimulus(1'b1, 6'b000000, 16'h0100, 16'h0100, 0, 1'b0);
        applyStimulus(1'b1, 6'b000000, 16'h1234, 16'h0000, 0, 1'b0);
        applyStimulus(1'b1, 6'b000000, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        applyStimulus(1'b0, 6'b010011, 16'd10, 16'd4, 0, 1'b0);
        applyStimulus(1'b0, 6'b000000, 16'hF0F0, 16'h3C3C, 0, 1'b0);
        applyStimulus(1'b1, 6'b000000, 16'd9, 16'd9, 5, 1'b1);

        // Abort a multiply mid-way: no result may survive the reset
        @(negedge clk);
        start_valid = 1'b1;
        op = 1'b1;
        ctrl = 6'h00;
        a = 16'h1234;
        b = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("mid-mul reset");
        @(negedge clk);
        checkResetState("held reset");
        rst_n = 1'b1;
        applyStimulus(1'b0, 6'b000010, 16'h0000, 16'h0000, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom), 6'($urandom), 16'($urandom), 16'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have clk, input, 1, rising-edge system clock.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have start_valid, input, 1, request present.
REQ-004 SHALL have start_ready, output, 1, block can accept a request.
REQ-005 SHALL have op, input, 1, operation: 0 = PASS (single ALU operation), 1 = MUL (16x16 multiply, low 16 bits).
REQ-006 SHALL have ctrl, input, 6, ALU control {zx,nx,zy,ny,f,no} used by PASS and ignored by MUL.
REQ-007 SHALL have a, input, 16, signed operand x / multiplicand.
REQ-008 SHALL have b, input, 16, signed operand y / multiplier.
REQ-009 SHALL have res, output, 16, registered result.
REQ-010 SHALL have res_valid, output, 1, res is valid.
REQ-011 SHALL have res_ready, input, 1, consumer accepts res.
REQ-012 SHALL have zr, output, 1, res == 0; ng, output, 1, res[15].
REQ-013 SHALL have busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, PASS, MUL and DONE.
REQ-015 start_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with start_valid && start_ready, and a, b, op and ctrl are captured then.
REQ-016 PASS SHALL apply the captured ctrl to the ALU with x=a and y=b, load res on the next edge, and enter DONE; res_valid rises 2 edges after acceptance.
REQ-017 MUL SHALL use shift-add with acc=0, mcand=a and mplier=b; each cycle, if mplier[0] then acc = ALU(acc, mcand, ctrl=ADD 6'b000010); then mcand is shifted left 1 and mplier is shifted right 1 (logical shift).
REQ-018 Without early exit, MUL SHALL run exactly 16 iterations, then load res=acc and enter DONE; res_valid rises 17 edges after acceptance.
REQ-019 Arithmetic SHALL be modulo 2^16; signed and unsigned low halves are identical, and no overflow flag is produced.
REQ-020 DONE SHALL hold res_valid=1 with res stable until res_ready=1, then return to IDLE on that edge.
REQ-021 res_ready=1 in DONE SHALL NOT accept a new request on the same edge; start_ready rises the cycle after.
REQ-022 start_valid outside IDLE SHALL be ignored.
REQ-023 zr and ng SHALL be combinational from the res register.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, res=0, res_valid=0 and all internal registers to 0, which gives start_ready=1, busy=0, zr=1 and ng=0.
REQ-025 A reset during PASS, MUL or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-026 With ALU_MUL_EARLY_EXIT_EN defined, MUL SHALL leave for DONE after the iteration in which the shifted mplier becomes 0, and b==0 SHALL give one iteration with res=0.
REQ-027 With ALU_MUL_EARLY_EXIT_EN undefined, MUL SHALL always take 16 iterations (REQ-018).
REQ-028 Results SHALL be identical in both builds; only latency differs.

Structure
REQ-029 Package alu_seq_pkg SHALL hold the state enum, the op encodings (OP_PASS, OP_MUL), ALU_CTRL_ADD=6'b000010 and MUL_ITERS=16.
REQ-030 Exactly one instance of the existing ALU combinational module SHALL be instantiated, with its x, y and control inputs muxed by state; no other adder is permitted.

Verification
REQ-031 SHALL cover: PASS, ctrl=000010, a=3, b=5 -> res=8, zr=0, ng=0, res_valid 2 edges after accept.
REQ-032 SHALL cover: MUL a=7, b=6 -> res=42; latency 17 edges without the macro, 4 edges with the macro (3 iterations).
REQ-033 SHALL cover: MUL a=-3, b=5 -> res=16'hFFF1, ng=1; MUL a=16'h0100, b=16'h0100 -> res=0, zr=1 (wrap).
REQ-034 SHALL cover: res_ready low for 5 cycles in DONE with start_valid high -> res stable, start_ready=0, no new accept; one cycle after res_ready, start_ready=1.
REQ-035 SHALL cover: rst_n pulsed low at iteration 8 of MUL -> outputs immediately at reset values; a following PASS a=0, b=0, ctrl=000010 -> res=0, zr=1.
